// File: rtl/if_fetch_queue_pkg.sv
// Shared constants and helpers for the instruction prefetch queue and the CPU top that hosts it.
// Optional feature macro used by the queue: IFQ_BYPASS_EN.
package if_fetch_queue_pkg;

    localparam int          PC_LENGTH   = 32;
    localparam int          INST_LENGTH = 32;
    localparam int          IFQ_DEPTH   = 4;
    localparam logic        ENABLE      = 1'b1;
    localparam logic        DISABLE     = 1'b0;
    localparam logic [31:0] PC_START    = 32'h0000_0000;

    typedef enum logic [1:0] {
        CNT_HOLD  = 2'd0,
        CNT_INC   = 2'd1,
        CNT_DEC   = 2'd2,
        CNT_CLEAR = 2'd3
    } cnt_op_e;

    // Occupancy update: clearing wins, a simultaneous write and read cancel out.
    function automatic cnt_op_e count_op(input logic clear, input logic wr, input logic rd);
        cnt_op_e op;
        if (clear) begin
            op = CNT_CLEAR;
        end else if (wr && !rd) begin
            op = CNT_INC;
        end else if (rd && !wr) begin
            op = CNT_DEC;
        end else begin
            op = CNT_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/if_fetch_queue_ram.sv
// Storage array for the prefetch queue: synchronous write, combinational read, data never reset.
module if_fetch_queue_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Entry write on accepted push.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction prefetch queue between fetch and decode; flush discards wrong-path entries.
// Optional macro IFQ_BYPASS_EN: zero-latency pass-through when the queue is empty.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INST_W-1:0]        in_inst,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [PC_W-1:0]          out_pc,
    output logic [INST_W-1:0]        out_inst,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              CW       = AW + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1'b1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1'b1);

    logic [AW-1:0]          wr_ptr_r;
    logic [AW-1:0]          rd_ptr_r;
    logic [CW-1:0]          count_r;
    logic [PC_W+INST_W-1:0] rd_data_s;
    logic                   empty_s;
    logic                   bypass_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   take_bypass_s;
    logic                   wr_en_s;
    logic                   rd_adv_s;
    cnt_op_e                cnt_op_s;

    assign count    = count_r;
    assign in_ready = (count_r != FULL_CNT);
    assign empty_s  = (count_r == {CW{1'b0}});

`ifdef IFQ_BYPASS_EN
    assign bypass_s = empty_s & in_valid & ~flush;
`else
    assign bypass_s = 1'b0;
`endif

    // Head presentation: stored entry first, bypassed fetch only when empty, zeros otherwise.
    always_comb begin
        out_valid = 1'b0;
        out_pc    = {PC_W{1'b0}};
        out_inst  = {INST_W{1'b0}};
        if (!empty_s) begin
            out_valid = 1'b1;
            {out_pc, out_inst} = rd_data_s;
        end else if (bypass_s) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_inst  = in_inst;
        end else begin
            out_valid = 1'b0;
        end
    end

    assign push_s        = in_valid & in_ready;
    assign pop_s         = out_valid & out_ready;
    // A bypassed entry consumed in the same cycle never touches the array.
    assign take_bypass_s = bypass_s & out_ready;
    assign wr_en_s       = push_s & ~take_bypass_s & ~flush & ~rst;
    assign rd_adv_s      = pop_s & ~take_bypass_s;
    assign cnt_op_s      = count_op(rst | flush, wr_en_s, rd_adv_s);

    // Pointer registers; power-of-two depth lets them wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_adv_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        case (cnt_op_s)
            CNT_CLEAR: count_r <= {CW{1'b0}};
            CNT_INC:   count_r <= count_r + CNT_ONE;
            CNT_DEC:   count_r <= count_r - CNT_ONE;
            CNT_HOLD:  count_r <= count_r;
            default:   count_r <= {CW{1'b0}};
        endcase
    end

    if_fetch_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (PC_W + INST_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_r),
        .wr_data ({in_pc, in_inst}),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_data_s)
    );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed and randomized bench for if_fetch_queue against a queue-based reference model.
module tb_if_fetch_queue;

    localparam int DEPTH  = 4;
    localparam int PC_W   = 32;
    localparam int INST_W = 32;
    localparam int CW     = $clog2(DEPTH) + 1;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [PC_W-1:0]   in_pc = '0;
    logic [INST_W-1:0] in_inst = '0;
    logic              in_ready;
    logic              flush = 1'b0;
    logic              out_valid;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_ready = 1'b0;
    logic [CW-1:0]     count;

    if_fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_pc(out_pc),
        .out_inst(out_inst), .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    bit          armed = 1'b0;
    logic [63:0] q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], 16'hC0DE} ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: drive, check against model, clock, update model.
    task automatic cycle(input logic r, input logic v, input logic [31:0] pc,
                         input logic f, input logic rdy, output bit acc);
        int          sz;
        bit          byp, exp_valid, push, pop;
        logic [63:0] exp_out;
        @(negedge clk);
        rst = r; in_valid = v; in_pc = pc; in_inst = inst_of(pc); flush = f; out_ready = rdy;
        #1;
        sz        = q.size();
        byp       = BYP && (sz == 0) && v && !f;
        exp_valid = (sz != 0) || byp;
        exp_out   = (sz != 0) ? q[0] : (byp ? {pc, inst_of(pc)} : 64'd0);
        if (armed) begin
            check("count",     64'(count),              64'(sz));
            check("in_ready",  64'(in_ready),           64'(sz != DEPTH));
            check("out_valid", 64'(out_valid),          64'(exp_valid));
            check("out_data",  {out_pc, out_inst},      exp_out);
        end
        @(posedge clk);
        acc = 1'b0;
        if (r || f) begin
            q.delete();
        end else begin
            push = v && (sz != DEPTH);
            pop  = exp_valid && rdy;
            acc  = push;
            if (!(byp && pop)) begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back({pc, inst_of(pc)});
            end
        end
        if (r) armed = 1'b1;
    endtask

    initial begin
        bit          acc;
        bit          hold;
        bit          v;
        logic [31:0] npc;
        // Reset then idle
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, acc);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, acc);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, acc);
        // Fill, refused fifth push, drain
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 32'(i * 4), 1'b0, 1'b0, acc);
        cycle(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, acc);
        check("full_refused", 64'(acc), 64'd0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, acc);
        // Streaming across pointer wrap
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 32'(i * 4), 1'b0, 1'b1, acc);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, acc);
        // Flush mid-operation
        for (int i = 1; i <= 3; i++) cycle(1'b0, 1'b1, 32'(i * 4), 1'b0, 1'b0, acc);
        cycle(1'b0, 1'b1, 32'h10, 1'b1, 1'b1, acc);
        cycle(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, acc);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, acc);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, acc);
        // Reset beats flush and push
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'(32'h80 + i * 4), 1'b0, 1'b0, acc);
        cycle(1'b1, 1'b1, 32'h90, 1'b1, 1'b0, acc);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, acc);
        // Empty-queue pass-through case (zero latency only with the bypass build)
        cycle(1'b0, 1'b1, 32'h20, 1'b0, 1'b1, acc);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, acc);
        // Randomized traffic with fetch holding data until accepted
        npc  = 32'h100;
        hold = 1'b0;
        v    = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic r, f, rdy;
            r   = ($urandom_range(0, 99) == 0);
            f   = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            if (!hold) v = ($urandom_range(0, 3) != 0);
            cycle(r, v, npc, f, rdy, acc);
            if (r || f) begin
                npc  = {$urandom_range(0, 16'hFFFF), 2'b00};
                hold = 1'b0;
            end else if (v && acc) begin
                npc  = npc + 32'd4;
                hold = 1'b0;
            end else begin
                hold = v;
            end
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, acc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
